// File: rtl/dut_top_fsm.sv
// dut_top_fsm: serial PATTERN detector with a one-cycle registered match strobe z.
// Optional DUT_TOP_MATCH_COUNT_EN adds a saturating 8-bit match counter output.
module dut_top_fsm #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1010,
    parameter bit                     OVERLAP     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x,
`ifdef DUT_TOP_MATCH_COUNT_EN
    output logic [7:0] match_count,
`endif
    output logic       z
);
    localparam int FW = $clog2(PATTERN_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN);

    logic [PATTERN_LEN-1:0] sr, sr_next;
    logic [FW-1:0]          fill, fill_inc, fill_next;
    logic                   match_next;

    always_comb begin
        sr_next    = {sr[PATTERN_LEN-2:0], x};
        fill_inc   = (fill == FULL) ? fill : fill + 1'b1;
        // Fill gates the compare so reset contents never count as matched bits.
        match_next = (fill_inc == FULL) && (sr_next == PATTERN);
        fill_next  = (!OVERLAP && match_next) ? '0 : fill_inc;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sr   <= '0;
            fill <= '0;
            z    <= 1'b0;
        end else begin
            sr   <= sr_next;
            fill <= fill_next;
            z    <= match_next;
        end
    end

`ifdef DUT_TOP_MATCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst_n)
            match_count <= 8'd0;
        else if (match_next && match_count != 8'hFF)
            match_count <= match_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_dut_top_fsm.sv
// tb_dut_top_fsm: scoreboard bench driving three detector variants with directed vectors.
module tb_dut_top_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic x = 1'b0;
    logic z0, z1, z2;
`ifdef DUT_TOP_MATCH_COUNT_EN
    logic [7:0] mc0, mc1, mc2;
`endif

    always #5 clk = ~clk;

    dut_top_fsm #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .x(x),
`ifdef DUT_TOP_MATCH_COUNT_EN
        .match_count(mc0),
`endif
        .z(z0));
    dut_top_fsm #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .x(x),
`ifdef DUT_TOP_MATCH_COUNT_EN
        .match_count(mc1),
`endif
        .z(z1));
    dut_top_fsm #(.PATTERN_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .x(x),
`ifdef DUT_TOP_MATCH_COUNT_EN
        .match_count(mc2),
`endif
        .z(z2));

    typedef struct packed {
        logic e0;
        logic e1;
        logic e2;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int step = 0;

    task automatic chk(input string n, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", n, step, got, want);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge, checked just after the edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("z_ovl_1010", {7'd0, z0}, {7'd0, e.e0});
            chk("z_novl_1010", {7'd0, z1}, {7'd0, e.e1});
            chk("z_ovl_0000", {7'd0, z2}, {7'd0, e.e2});
            step++;
        end
    end

    task automatic drive(input logic r, input logic xv, input logic e0, input logic e1, input logic e2);
        @(negedge clk);
        rst_n = r;
        x = xv;
        q.push_back({e0, e1, e2});
    endtask

    // 'R' = reset with x=1, 'r' = reset with x=0, '0'/'1' = data bit.
    task automatic seq(input string xs, input string s0, input string s1, input string s2);
        for (int i = 0; i < xs.len(); i++) begin
            drive(xs.getc(i) == "R" || xs.getc(i) == "r",
                  xs.getc(i) == "R" || xs.getc(i) == "1",
                  s0.getc(i) == "1", s1.getc(i) == "1", s2.getc(i) == "1");
        end
    endtask

    initial begin
        int n;
        seq("RR1010101011", "000001010100", "000001000100", "000000000000");
        seq("101r01010",    "000000001",    "000000001",    "000000000");
        seq("r0000001",     "00000000",     "00000000",     "00001110");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DUT_TOP_MATCH_COUNT_EN
        @(posedge clk);
        #2;
        chk("mc_reset", mc0, 8'd0);
        n = 606;
`else
        n = 40;
`endif
        for (int i = 0; i < n; i++)
            drive(1'b0, (i % 2) == 0, i >= 3 && (i % 2) == 1, (i % 4) == 3, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
`ifdef DUT_TOP_MATCH_COUNT_EN
        chk("mc_sat_ovl", mc0, 8'd255);
        chk("mc_novl", mc1, 8'd151);
        chk("mc_zero_pat", mc2, 8'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
